multi_alarm_clock: RTL and testbench

- Parametrised successor to the single-clock time core: 24-hour time-of-day counter plus NUM_ALARMS independently programmable alarms.
- Ring/snooze/dismiss state machine with auto-timeout.
- Sits between the keyboard time-entry block (set pulses and values) and the seven-segment display block (hour/minute/second, ringing status).
- Generates its own 1 Hz tick from the system clock.

---
 rtl/clock_pkg.sv | 25 ++
 rtl/multi_alarm_clock_if.sv | 49 ++++
 rtl/second_tick_gen.sv | 37 +++
 rtl/multi_alarm_clock.sv | 232 +++++++++++++++++++++++
 tb/tb_multi_alarm_clock.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared constants, FSM encoding and field-range helper for the
// multi-alarm time-of-day core.
package clock_pkg;

    localparam int TIME_W = 6;

    localparam logic [TIME_W-1:0] MAX_HOUR = 6'd23;
    localparam logic [TIME_W-1:0] MAX_MIN  = 6'd59;
    localparam logic [TIME_W-1:0] MAX_SEC  = 6'd59;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } state_e;

    function automatic logic time_fields_ok(
        input logic [TIME_W-1:0] h,
        input logic [TIME_W-1:0] m,
        input logic [TIME_W-1:0] s
    );
        return (h <= MAX_HOUR) && (m <= MAX_MIN) && (s <= MAX_SEC);
    endfunction

endpackage

// File: rtl/multi_alarm_clock_if.sv
// Control/status bundle between the time-entry block, the alarm clock core
// and the display block.
interface multi_alarm_clock_if
    import clock_pkg::*;
#(
    parameter int NUM_ALARMS = 4,
    parameter int IDX_W      = 2
);

    logic                  run_en;
    logic                  set_time_en;
    logic [TIME_W-1:0]     hour_set;
    logic [TIME_W-1:0]     minute_set;
    logic [TIME_W-1:0]     second_set;
    logic                  alarm_wr_en;
    logic [IDX_W-1:0]      alarm_wr_idx;
    logic [TIME_W-1:0]     alarm_hour;
    logic [TIME_W-1:0]     alarm_minute;
    logic                  alarm_on;
    logic                  snooze;
    logic                  dismiss;

    logic [TIME_W-1:0]     hour;
    logic [TIME_W-1:0]     minute;
    logic [TIME_W-1:0]     second;
    logic                  tick;
    logic                  ringing;
    logic                  snoozing;
    logic [IDX_W-1:0]      ring_idx;
    logic [NUM_ALARMS-1:0] alarm_mask;
    logic                  set_err;

    modport master (
        output run_en, set_time_en, hour_set, minute_set, second_set,
        output alarm_wr_en, alarm_wr_idx, alarm_hour, alarm_minute, alarm_on,
        output snooze, dismiss,
        input  hour, minute, second, tick, ringing, snoozing,
        input  ring_idx, alarm_mask, set_err
    );

    modport slave (
        input  run_en, set_time_en, hour_set, minute_set, second_set,
        input  alarm_wr_en, alarm_wr_idx, alarm_hour, alarm_minute, alarm_on,
        input  snooze, dismiss,
        output hour, minute, second, tick, ringing, snoozing,
        output ring_idx, alarm_mask, set_err
    );

endinterface

// File: rtl/second_tick_gen.sv
// Divides the system clock down to a one-cycle tick per elapsed second;
// freezes while run_en is low and restarts from zero on clear.
module second_tick_gen #(
    parameter int CLK_HZ = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_en,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt_r;

    assign tick = run_en && (cnt_r == CNT_MAX);

    // Prescaler count: clear wins, otherwise advance and wrap while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (run_en) begin
            if (cnt_r == CNT_MAX) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/multi_alarm_clock.sv
// 24-hour time-of-day counter with NUM_ALARMS programmable alarms and a
// ring/snooze/dismiss state machine with automatic ring timeout.
module multi_alarm_clock
    import clock_pkg::*;
#(
    parameter int CLK_HZ         = 50000000,
    parameter int NUM_ALARMS     = 4,
    parameter int IDX_W          = 2,
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_MINUTES = 5
) (
    input  logic              CLK_50,
    input  logic              reset_en,
    multi_alarm_clock_if.slave cif
);

    localparam int SNZ_TICKS = SNOOZE_MINUTES * 60;
    localparam int RC_W      = $clog2(RING_SECONDS + 1);
    localparam int SC_W      = $clog2(SNZ_TICKS + 1);
    localparam logic [RC_W-1:0] RING_LOAD = RC_W'(RING_SECONDS);
    localparam logic [SC_W-1:0] SNZ_LOAD  = SC_W'(SNZ_TICKS);

    logic                  tick_s;
    logic                  set_ok_s;
    logic                  idx_ok_s;
    logic                  wr_ok_s;
    logic                  disable_s;
    logic                  match_s;
    logic                  match_ev_s;
    logic [IDX_W-1:0]      winner_s;

    logic [TIME_W-1:0]     hour_r, minute_r, second_r;
    logic [TIME_W-1:0]     hour_n, minute_n, second_n;
    logic                  tick_d_r;
    logic                  set_err_r;

    logic [TIME_W-1:0]     al_hour_r [NUM_ALARMS];
    logic [TIME_W-1:0]     al_min_r  [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] al_en_r;

    state_e                state_r, state_n;
    logic [RC_W-1:0]       ring_cnt_r, ring_cnt_n;
    logic [SC_W-1:0]       snz_cnt_r, snz_cnt_n;
    logic [IDX_W-1:0]      ring_idx_r, ring_idx_n;
    logic                  ringing_r, snoozing_r;

    second_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick (
        .clk    (CLK_50),
        .rst_n  (reset_en),
        .run_en (cif.run_en),
        .clear  (set_ok_s),
        .tick   (tick_s)
    );

    assign set_ok_s  = cif.set_time_en &&
                       time_fields_ok(cif.hour_set, cif.minute_set, cif.second_set);
    assign idx_ok_s  = (32'(cif.alarm_wr_idx) < NUM_ALARMS);
    assign wr_ok_s   = cif.alarm_wr_en && idx_ok_s &&
                       time_fields_ok(cif.alarm_hour, cif.alarm_minute, '0);
    // Only a write that turns off the alarm currently ringing/snoozing aborts it.
    assign disable_s = wr_ok_s && !cif.alarm_on && (cif.alarm_wr_idx == ring_idx_r);

    // Next time-of-day: a valid load overrides (and discards) a same-cycle tick.
    always_comb begin
        hour_n   = hour_r;
        minute_n = minute_r;
        second_n = second_r;
        if (set_ok_s) begin
            hour_n   = cif.hour_set;
            minute_n = cif.minute_set;
            second_n = cif.second_set;
        end else if (tick_s) begin
            if (second_r == MAX_SEC) begin
                second_n = '0;
                if (minute_r == MAX_MIN) begin
                    minute_n = '0;
                    hour_n   = (hour_r == MAX_HOUR) ? '0 : hour_r + TIME_W'(1);
                end else begin
                    minute_n = minute_r + TIME_W'(1);
                end
            end else begin
                second_n = second_r + TIME_W'(1);
            end
        end else begin
            second_n = second_r;
        end
    end

    // Time registers, tick-update marker and rejected-write pulse.
    always_ff @(posedge CLK_50 or negedge reset_en) begin
        if (!reset_en) begin
            hour_r    <= '0;
            minute_r  <= '0;
            second_r  <= '0;
            tick_d_r  <= 1'b0;
            set_err_r <= 1'b0;
        end else begin
            hour_r    <= hour_n;
            minute_r  <= minute_n;
            second_r  <= second_n;
            tick_d_r  <= tick_s && !set_ok_s;
            set_err_r <= (cif.set_time_en && !set_ok_s) || (cif.alarm_wr_en && !wr_ok_s);
        end
    end

    // Alarm table: one entry rewritten per valid write pulse.
    always_ff @(posedge CLK_50 or negedge reset_en) begin
        if (!reset_en) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                al_hour_r[i] <= '0;
                al_min_r[i]  <= '0;
            end
            al_en_r <= '0;
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (wr_ok_s && (cif.alarm_wr_idx == IDX_W'(i))) begin
                    al_hour_r[i] <= cif.alarm_hour;
                    al_min_r[i]  <= cif.alarm_minute;
                    al_en_r[i]   <= cif.alarm_on;
                end else begin
                    al_hour_r[i] <= al_hour_r[i];
                    al_min_r[i]  <= al_min_r[i];
                    al_en_r[i]   <= al_en_r[i];
                end
            end
        end
    end

    // Priority search from the top down so the lowest matching index wins.
    always_comb begin
        match_s  = 1'b0;
        winner_s = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (al_en_r[i] && (al_hour_r[i] == hour_r) && (al_min_r[i] == minute_r)) begin
                match_s  = 1'b1;
                winner_s = IDX_W'(i);
            end else begin
                winner_s = winner_s;
            end
        end
    end

    assign match_ev_s = tick_d_r && (second_r == '0) && match_s;

    // Ring/snooze FSM: dismiss > disabling write > snooze > counter expiry.
    always_comb begin
        state_n    = state_r;
        ring_cnt_n = ring_cnt_r;
        snz_cnt_n  = snz_cnt_r;
        ring_idx_n = ring_idx_r;
        case (state_r)
            ST_IDLE: begin
                if (match_ev_s) begin
                    state_n    = ST_RING;
                    ring_idx_n = winner_s;
                    ring_cnt_n = RING_LOAD;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_RING: begin
                if (cif.dismiss || disable_s) begin
                    state_n = ST_IDLE;
                end else if (cif.snooze) begin
                    state_n   = ST_SNOOZE;
                    snz_cnt_n = SNZ_LOAD;
                end else if (tick_s) begin
                    ring_cnt_n = ring_cnt_r - RC_W'(1);
                    if (ring_cnt_r <= RC_W'(1)) begin
                        state_n    = ST_IDLE;
                        ring_cnt_n = '0;
                    end else begin
                        state_n = ST_RING;
                    end
                end else begin
                    state_n = ST_RING;
                end
            end
            ST_SNOOZE: begin
                if (cif.dismiss || disable_s) begin
                    state_n = ST_IDLE;
                end else if (tick_s) begin
                    snz_cnt_n = snz_cnt_r - SC_W'(1);
                    if (snz_cnt_r <= SC_W'(1)) begin
                        state_n    = ST_RING;
                        snz_cnt_n  = '0;
                        ring_cnt_n = RING_LOAD;
                    end else begin
                        state_n = ST_SNOOZE;
                    end
                end else begin
                    state_n = ST_SNOOZE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // FSM state, counters and registered status flags.
    always_ff @(posedge CLK_50 or negedge reset_en) begin
        if (!reset_en) begin
            state_r    <= ST_IDLE;
            ring_cnt_r <= '0;
            snz_cnt_r  <= '0;
            ring_idx_r <= '0;
            ringing_r  <= 1'b0;
            snoozing_r <= 1'b0;
        end else begin
            state_r    <= state_n;
            ring_cnt_r <= ring_cnt_n;
            snz_cnt_r  <= snz_cnt_n;
            ring_idx_r <= ring_idx_n;
            ringing_r  <= (state_n == ST_RING);
            snoozing_r <= (state_n == ST_SNOOZE);
        end
    end

    assign cif.hour       = hour_r;
    assign cif.minute     = minute_r;
    assign cif.second     = second_r;
    assign cif.tick       = tick_s;
    assign cif.ringing    = ringing_r;
    assign cif.snoozing   = snoozing_r;
    assign cif.ring_idx   = ring_idx_r;
    assign cif.alarm_mask = al_en_r;
    assign cif.set_err    = set_err_r;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed bench for multi_alarm_clock with a 4-cycle second, 3-second
// ring timeout and 1-minute snooze.
module tb_multi_alarm_clock;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    multi_alarm_clock_if #(.NUM_ALARMS(4), .IDX_W(2)) bus ();

    multi_alarm_clock #(
        .CLK_HZ         (4),
        .NUM_ALARMS     (4),
        .IDX_W          (2),
        .RING_SECONDS   (3),
        .SNOOZE_MINUTES (1)
    ) dut (
        .CLK_50   (clk),
        .reset_en (rst_n),
        .cif      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_time(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
        bus.hour_set = h; bus.minute_set = m; bus.second_set = s;
        bus.set_time_en = 1'b1;
        cyc(1);
        bus.set_time_en = 1'b0;
    endtask

    task automatic write_alarm(input logic [1:0] idx, input logic [5:0] h,
                               input logic [5:0] m, input logic on);
        bus.alarm_wr_idx = idx; bus.alarm_hour = h; bus.alarm_minute = m;
        bus.alarm_on = on; bus.alarm_wr_en = 1'b1;
        cyc(1);
        bus.alarm_wr_en = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({bus.hour, bus.minute, bus.second} !== 18'd0) begin
            n_err++; $display("FAIL reset_time: got %h expected 0", {bus.hour, bus.minute, bus.second});
        end
        n_cmp++;
        if ({bus.tick, bus.ringing, bus.snoozing, bus.set_err, bus.ring_idx, bus.alarm_mask} !== 10'd0) begin
            n_err++; $display("FAIL reset_status: got %h expected 0",
                {bus.tick, bus.ringing, bus.snoozing, bus.set_err, bus.ring_idx, bus.alarm_mask});
        end
    endtask

    task automatic test_rollover();
        bus.run_en = 1'b1;
        load_time(6'd23, 6'd59, 6'd58);
        n_cmp++;
        if ({bus.hour, bus.minute, bus.second, bus.set_err} !== {6'd23, 6'd59, 6'd58, 1'b0}) begin
            n_err++; $display("FAIL load_time: got %0d:%0d:%0d err=%0d expected 23:59:58 err=0",
                bus.hour, bus.minute, bus.second, bus.set_err);
        end
        cyc(3);
        n_cmp++;
        if ({bus.tick, bus.second} !== {1'b1, 6'd58}) begin
            n_err++; $display("FAIL first_tick: got tick=%0d sec=%0d expected tick=1 sec=58", bus.tick, bus.second);
        end
        cyc(1);
        n_cmp++;
        if ({bus.tick, bus.hour, bus.minute, bus.second} !== {1'b0, 6'd23, 6'd59, 6'd59}) begin
            n_err++; $display("FAIL to_235959: got tick=%0d %0d:%0d:%0d expected tick=0 23:59:59",
                bus.tick, bus.hour, bus.minute, bus.second);
        end
        cyc(4);
        n_cmp++;
        if ({bus.hour, bus.minute, bus.second, bus.set_err} !== {6'd0, 6'd0, 6'd0, 1'b0}) begin
            n_err++; $display("FAIL day_wrap: got %0d:%0d:%0d err=%0d expected 0:0:0 err=0",
                bus.hour, bus.minute, bus.second, bus.set_err);
        end
        bus.run_en = 1'b0;
    endtask

    task automatic test_invalid_writes();
        load_time(6'd24, 6'd0, 6'd0);
        n_cmp++;
        if ({bus.set_err, bus.hour, bus.minute, bus.second} !== {1'b1, 18'd0}) begin
            n_err++; $display("FAIL bad_hour: got err=%0d %0d:%0d:%0d expected err=1 0:0:0",
                bus.set_err, bus.hour, bus.minute, bus.second);
        end
        cyc(1);
        n_cmp++;
        if (bus.set_err !== 1'b0) begin
            n_err++; $display("FAIL err_one_cycle: got %0d expected 0", bus.set_err);
        end
        write_alarm(2'd2, 6'd7, 6'd60, 1'b1);
        n_cmp++;
        if ({bus.set_err, bus.alarm_mask} !== {1'b1, 4'b0000}) begin
            n_err++; $display("FAIL bad_alarm_min: got err=%0d mask=%b expected err=1 mask=0000",
                bus.set_err, bus.alarm_mask);
        end
        write_alarm(2'd2, 6'd23, 6'd59, 1'b1);
        n_cmp++;
        if ({bus.set_err, bus.alarm_mask} !== {1'b0, 4'b0100}) begin
            n_err++; $display("FAIL edge_alarm: got err=%0d mask=%b expected err=0 mask=0100",
                bus.set_err, bus.alarm_mask);
        end
        write_alarm(2'd2, 6'd23, 6'd59, 1'b0);
    endtask

    // Load start time and run until the alarm at (eh:em) starts ringing.
    task automatic arm_and_ring(input logic [5:0] sh, input logic [5:0] sm,
                                input logic [5:0] eh, input logic [5:0] em,
                                input logic [1:0] exp_idx);
        bus.run_en = 1'b1;
        load_time(sh, sm, 6'd58);
        cyc(8);
        n_cmp++;
        if ({bus.hour, bus.minute, bus.second, bus.ringing} !== {eh, em, 6'd0, 1'b0}) begin
            n_err++; $display("FAIL pre_ring: got %0d:%0d:%0d ringing=%0d expected %0d:%0d:0 ringing=0",
                bus.hour, bus.minute, bus.second, bus.ringing, eh, em);
        end
        cyc(1);
        n_cmp++;
        if ({bus.ringing, bus.snoozing, bus.ring_idx} !== {1'b1, 1'b0, exp_idx}) begin
            n_err++; $display("FAIL ring_start: got ringing=%0d snoozing=%0d idx=%0d expected 1 0 %0d",
                bus.ringing, bus.snoozing, bus.ring_idx, exp_idx);
        end
    endtask

    task automatic test_alarm_autostop();
        write_alarm(2'd1, 6'd7, 6'd0, 1'b1);
        write_alarm(2'd3, 6'd7, 6'd0, 1'b1);
        n_cmp++;
        if (bus.alarm_mask !== 4'b1010) begin
            n_err++; $display("FAIL mask_1_3: got %b expected 1010", bus.alarm_mask);
        end
        bus.run_en = 1'b1;
        load_time(6'd7, 6'd0, 6'd0);
        cyc(2);
        n_cmp++;
        if (bus.ringing !== 1'b0) begin
            n_err++; $display("FAIL loaded_no_match: got ringing=%0d expected 0", bus.ringing);
        end
        arm_and_ring(6'd6, 6'd59, 6'd7, 6'd0, 2'd1);
        cyc(10);
        n_cmp++;
        if (bus.ringing !== 1'b1) begin
            n_err++; $display("FAIL ring_hold: got %0d expected 1", bus.ringing);
        end
        cyc(1);
        n_cmp++;
        if ({bus.ringing, bus.snoozing} !== 2'b00) begin
            n_err++; $display("FAIL auto_stop: got %b expected 00", {bus.ringing, bus.snoozing});
        end
    endtask

    task automatic test_snooze();
        arm_and_ring(6'd6, 6'd59, 6'd7, 6'd0, 2'd1);
        bus.snooze = 1'b1; cyc(1); bus.snooze = 1'b0;
        n_cmp++;
        if ({bus.ringing, bus.snoozing} !== 2'b01) begin
            n_err++; $display("FAIL enter_snooze: got %b expected 01", {bus.ringing, bus.snoozing});
        end
        cyc(100);
        bus.snooze = 1'b1; cyc(1); bus.snooze = 1'b0;
        cyc(136);
        n_cmp++;
        if ({bus.ringing, bus.snoozing} !== 2'b01) begin
            n_err++; $display("FAIL snooze_hold: got %b expected 01", {bus.ringing, bus.snoozing});
        end
        cyc(1);
        n_cmp++;
        if ({bus.ringing, bus.snoozing, bus.ring_idx} !== {2'b10, 2'd1}) begin
            n_err++; $display("FAIL re_ring: got r=%0d s=%0d idx=%0d expected 1 0 1",
                bus.ringing, bus.snoozing, bus.ring_idx);
        end
        bus.dismiss = 1'b1; cyc(1); bus.dismiss = 1'b0;
        n_cmp++;
        if ({bus.ringing, bus.snoozing} !== 2'b00) begin
            n_err++; $display("FAIL dismiss: got %b expected 00", {bus.ringing, bus.snoozing});
        end
    endtask

    task automatic test_same_cycle();
        arm_and_ring(6'd6, 6'd59, 6'd7, 6'd0, 2'd1);
        bus.snooze = 1'b1; bus.dismiss = 1'b1; cyc(1);
        bus.snooze = 1'b0; bus.dismiss = 1'b0;
        n_cmp++;
        if ({bus.ringing, bus.snoozing} !== 2'b00) begin
            n_err++; $display("FAIL snooze_and_dismiss: got %b expected 00", {bus.ringing, bus.snoozing});
        end
        load_time(6'd10, 6'd0, 6'd0);
        cyc(3);
        n_cmp++;
        if (bus.tick !== 1'b1) begin
            n_err++; $display("FAIL tick_before_set: got %0d expected 1", bus.tick);
        end
        load_time(6'd12, 6'd34, 6'd56);
        n_cmp++;
        if ({bus.tick, bus.hour, bus.minute, bus.second} !== {1'b0, 6'd12, 6'd34, 6'd56}) begin
            n_err++; $display("FAIL set_beats_tick: got tick=%0d %0d:%0d:%0d expected 0 12:34:56",
                bus.tick, bus.hour, bus.minute, bus.second);
        end
        cyc(3);
        n_cmp++;
        if ({bus.tick, bus.second} !== {1'b1, 6'd56}) begin
            n_err++; $display("FAIL prescaler_cleared: got tick=%0d sec=%0d expected 1 56", bus.tick, bus.second);
        end
    endtask

    task automatic test_disable_write();
        bus.run_en = 1'b0;
        write_alarm(2'd0, 6'd8, 6'd0, 1'b1);
        n_cmp++;
        if (bus.alarm_mask !== 4'b1011) begin
            n_err++; $display("FAIL mask_0: got %b expected 1011", bus.alarm_mask);
        end
        arm_and_ring(6'd7, 6'd59, 6'd8, 6'd0, 2'd0);
        write_alarm(2'd0, 6'd8, 6'd0, 1'b0);
        n_cmp++;
        if ({bus.ringing, bus.snoozing, bus.alarm_mask} !== {2'b00, 4'b1010}) begin
            n_err++; $display("FAIL disable_ringing: got r=%0d s=%0d mask=%b expected 0 0 1010",
                bus.ringing, bus.snoozing, bus.alarm_mask);
        end
    endtask

    task automatic test_reset_mid_snooze();
        arm_and_ring(6'd6, 6'd59, 6'd7, 6'd0, 2'd1);
        bus.snooze = 1'b1; cyc(1); bus.snooze = 1'b0;
        cyc(5);
        n_cmp++;
        if (bus.snoozing !== 1'b1) begin
            n_err++; $display("FAIL pre_reset_snooze: got %0d expected 1", bus.snoozing);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.hour, bus.minute, bus.second, bus.tick, bus.ringing, bus.snoozing,
             bus.set_err, bus.ring_idx, bus.alarm_mask} !== 28'd0) begin
            n_err++; $display("FAIL async_reset: got %h expected 0",
                {bus.hour, bus.minute, bus.second, bus.tick, bus.ringing, bus.snoozing,
                 bus.set_err, bus.ring_idx, bus.alarm_mask});
        end
        cyc(1);
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.run_en = 1'b0; bus.set_time_en = 1'b0;
        bus.hour_set = 6'd0; bus.minute_set = 6'd0; bus.second_set = 6'd0;
        bus.alarm_wr_en = 1'b0; bus.alarm_wr_idx = 2'd0;
        bus.alarm_hour = 6'd0; bus.alarm_minute = 6'd0; bus.alarm_on = 1'b0;
        bus.snooze = 1'b0; bus.dismiss = 1'b0;
        #12;
        test_reset();
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        test_rollover();
        test_invalid_writes();
        test_alarm_autostop();
        test_snooze();
        test_same_cycle();
        test_disable_write();
        test_reset_mid_snooze();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
